// File: rtl/gpio_pad_ctrl.sv
// GPIO pad sequencer: release-turnaround-drive on direction/data changes,
// plus two-flop input synchronisation and sticky per-bit edge interrupts.
module gpio_pad_ctrl #(
    parameter int unsigned W        = 32,
    parameter int unsigned TURN_CYC = 2
) (
    input  logic         pclk,
    input  logic         preset,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_oe,
    input  logic [W-1:0] cfg_out,
    output logic         busy_o,
    output logic [W-1:0] out_pad_o,
    output logic [W-1:0] oen_padoe_o,
    input  logic [W-1:0] in_pad_i,
    output logic [W-1:0] gpio_in_o,
    input  logic [W-1:0] irq_rise_en_i,
    input  logic [W-1:0] irq_fall_en_i,
    input  logic [W-1:0] irq_mask_i,
    input  logic [W-1:0] irq_clr_i,
    output logic [W-1:0] irq_sts_o,
    output logic         irq_o
);

    typedef enum logic [1:0] {
        IDLE,
        RELEASE,
        TURN,
        APPLY
    } state_t;

    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC);

    state_t       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [W-1:0] sh_oe_q, sh_oe_d;
    logic [W-1:0] sh_out_q, sh_out_d;
    logic [W-1:0] oen_d, out_d;
    logic [W-1:0] sync1_q, sync2_q, prev_q;
    logic [W-1:0] evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_oe_d   = sh_oe_q;
        sh_out_d  = sh_out_q;
        oen_d     = oen_padoe_o;
        out_d     = out_pad_o;
        cfg_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    sh_oe_d  = cfg_oe;
                    sh_out_d = cfg_out;
                    // Only bits newly turning on need the turnaround gap
                    if ((cfg_oe & ~oen_padoe_o) == '0) begin
                        state_d = APPLY;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                oen_d   = oen_padoe_o & sh_oe_q;
                cnt_d   = TURN_LOAD;
                state_d = TURN;
            end
            TURN: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                out_d   = sh_out_q;
                oen_d   = sh_oe_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_oe_q     <= '0;
            sh_out_q    <= '0;
            oen_padoe_o <= '0;
            out_pad_o   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_oe_q     <= sh_oe_d;
            sh_out_q    <= sh_out_d;
            oen_padoe_o <= oen_d;
            out_pad_o   <= out_d;
        end
    end

    assign busy_o = ~cfg_ready;

    // Driven bits see their own output, so they never raise events
    assign evt = ((sync2_q & ~prev_q & irq_rise_en_i) |
                  (~sync2_q & prev_q & irq_fall_en_i)) & ~oen_padoe_o;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            irq_sts_o <= '0;
        end else begin
            sync1_q   <= in_pad_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            irq_sts_o <= (irq_sts_o & ~irq_clr_i) | evt;
        end
    end

    assign gpio_in_o = sync2_q;
    assign irq_o     = |(irq_sts_o & irq_mask_i);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios plus random traffic against a
// transaction-schedule model of the pad sequencer and input delay line.
module tb_gpio_pad_ctrl;

    localparam int unsigned TURN = 2;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready, busy;
    logic [31:0] cfg_oe = '0, cfg_out = '0;
    logic [31:0] out_pad, oen, gpio_in, sts;
    logic [31:0] in_pad = '0, rise_en = '0, fall_en = '0, mask = '0, clr = '0;
    logic        irq;

    gpio_pad_ctrl #(.W(32), .TURN_CYC(TURN)) dut (
        .pclk          (pclk),
        .preset        (preset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_oe        (cfg_oe),
        .cfg_out       (cfg_out),
        .busy_o        (busy),
        .out_pad_o     (out_pad),
        .oen_padoe_o   (oen),
        .in_pad_i      (in_pad),
        .gpio_in_o     (gpio_in),
        .irq_rise_en_i (rise_en),
        .irq_fall_en_i (fall_en),
        .irq_mask_i    (mask),
        .irq_clr_i     (clr),
        .irq_sts_o     (sts),
        .irq_o         (irq)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    // Model: scheduled release/apply edges per request, inputs as a delay line
    int          edge_n;
    bit          m_busy;
    int          rel_at, app_at;
    logic [31:0] m_oen, m_out, m_sh_oe, m_sh_out, m_sts;
    logic [31:0] in_hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] delayed(input int k);
        if (in_hist.size() > k) return in_hist[in_hist.size() - 1 - k];
        return '0;
    endfunction

    task automatic model_reset();
        edge_n = 0;
        m_busy = 1'b0;
        rel_at = -1;
        app_at = -1;
        m_oen = '0; m_out = '0; m_sh_oe = '0; m_sh_out = '0; m_sts = '0;
        in_hist.delete();
    endtask

    task automatic model_edge();
        logic [31:0] g, p, ev;
        if (preset) begin
            model_reset();
            return;
        end
        edge_n++;
        g  = delayed(1);
        p  = delayed(2);
        ev = ((g & ~p & rise_en) | (~g & p & fall_en)) & ~m_oen;
        m_sts = (m_sts & ~clr) | ev;
        in_hist.push_back(in_pad);
        if (in_hist.size() > 4) void'(in_hist.pop_front());
        if (!m_busy && cfg_valid) begin
            m_sh_oe  = cfg_oe;
            m_sh_out = cfg_out;
            m_busy   = 1'b1;
            if ((cfg_oe & ~m_oen) == 32'h0) begin
                rel_at = -1;
                app_at = edge_n + 1;
            end else begin
                rel_at = edge_n + 1;
                app_at = edge_n + 2 + int'(TURN);
            end
        end else if (m_busy && edge_n == rel_at) begin
            m_oen = m_oen & m_sh_oe;
        end else if (m_busy && edge_n == app_at) begin
            m_oen  = m_sh_oe;
            m_out  = m_sh_out;
            m_busy = 1'b0;
        end
    endtask

    task automatic check_all();
        check_eq("ready", 32'(cfg_ready), 32'(!m_busy));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("oen", oen, m_oen);
        check_eq("out", out_pad, m_out);
        check_eq("gpio_in", gpio_in, delayed(1));
        check_eq("sts", sts, m_sts);
        check_eq("irq", 32'(irq), 32'(|(m_sts & mask)));
    endtask

    task automatic step();
        @(posedge pclk);
        model_edge();
        @(negedge pclk);
        check_all();
    endtask

    initial begin
        preset = 1'b1;
        model_reset();
        repeat (2) @(negedge pclk);
        check_eq("rst_oen", oen, 32'h0);
        check_eq("rst_out", out_pad, 32'h0);
        check_eq("rst_ready", 32'(cfg_ready), 32'h1);
        check_all();
        preset = 1'b0;
        step();

        // Input -> output, slow path
        cfg_valid = 1'b1; cfg_oe = 32'hFFFF_FFFF; cfg_out = 32'hABCD_1234;
        step();
        cfg_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq("io_oen_held", oen, 32'h0);
            check_eq("io_busy", 32'(cfg_ready), 32'h0);
        end
        step();
        check_eq("io_oen", oen, 32'hFFFF_FFFF);
        check_eq("io_out", out_pad, 32'hABCD_1234);
        check_eq("io_ready", 32'(cfg_ready), 32'h1);

        // Fast path: only bits turning off
        cfg_valid = 1'b1; cfg_oe = 32'h0000_FFFF; cfg_out = 32'hDEAD_BEAD;
        step();
        cfg_valid = 1'b0;
        step();
        check_eq("fast_oen", oen, 32'h0000_FFFF);
        check_eq("fast_out", out_pad, 32'hDEAD_BEAD);
        check_eq("fast_ready", 32'(cfg_ready), 32'h1);

        // Mixed direction with an ignored request while busy
        cfg_valid = 1'b1; cfg_oe = 32'hFFFF_0000; cfg_out = 32'h1234_5678;
        step();
        cfg_oe = 32'h0; cfg_out = 32'h0;
        step();
        check_eq("mix_release", oen, 32'h0);
        cfg_valid = 1'b0;
        step();
        step();
        check_eq("mix_turn", oen, 32'h0);
        step();
        check_eq("mix_oen", oen, 32'hFFFF_0000);
        check_eq("mix_out", out_pad, 32'h1234_5678);
        repeat (3) step();
        check_eq("mix_ignored", oen, 32'hFFFF_0000);

        // Reset in the middle of TURN
        cfg_valid = 1'b1; cfg_oe = 32'hFFFF_FFFF; cfg_out = 32'h55AA_55AA;
        step();
        cfg_valid = 1'b0;
        step();
        step();
        preset = 1'b1;
        model_reset();
        #1;
        check_eq("mid_rst_oen", oen, 32'h0);
        check_eq("mid_rst_out", out_pad, 32'h0);
        check_eq("mid_rst_ready", 32'(cfg_ready), 32'h1);
        @(negedge pclk);
        preset = 1'b0;
        repeat (6) step();
        check_eq("mid_rst_noapply", oen, 32'h0);

        // Edge interrupt on bit 3
        rise_en = 32'h8; mask = 32'h8; in_pad = 32'h8;
        step();
        step();
        check_eq("irq_sync", gpio_in, 32'h8);
        step();
        check_eq("irq_sts", sts, 32'h8);
        check_eq("irq_out", 32'(irq), 32'h1);
        fall_en = 32'h8; in_pad = 32'h0;
        step();
        step();
        clr = 32'h8;
        step();
        clr = 32'h0;
        check_eq("irq_set_wins", sts, 32'h8);
        clr = 32'h8;
        step();
        clr = 32'h0;
        check_eq("irq_clear", sts, 32'h0);

        // Driven bit 5 follows on gpio_in but never raises status
        cfg_valid = 1'b1; cfg_oe = 32'h20; cfg_out = 32'h0;
        step();
        cfg_valid = 1'b0;
        repeat (5) step();
        rise_en = 32'h20; fall_en = 32'h20;
        for (int i = 0; i < 6; i++) begin
            in_pad = in_pad ^ 32'h20;
            repeat (3) step();
            check_eq("supp_gpio", gpio_in & 32'h20, in_pad & 32'h20);
            check_eq("supp_sts", sts & 32'h20, 32'h0);
        end

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: cfg_oe = $urandom;
                1: cfg_oe = '0;
                2: cfg_oe = '1;
                default: cfg_oe = m_oen ^ (32'h1 << $urandom_range(0, 31));
            endcase
            cfg_out = $urandom;
            in_pad  = in_pad ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) begin
                rise_en = $urandom; fall_en = $urandom; mask = $urandom;
            end
            clr = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom) : 32'h0;
            if ($urandom_range(0, 199) == 0) begin
                preset = 1'b1;
                model_reset();
                step();
                preset = 1'b0;
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
